arm_sequencer: RTL
==================

# arm_sequencer

Instruction sequencer for the 8-bit ARM datapath. It fetches 16-bit instruction words from program memory over a req/ack handshake and decodes each one into a single execute cycle of datapath controls: `calu`, `cpc`, `csrc`, `cmsrc`, `Lit`, `addr`, `wr_en`, `call`, `ret`, `push` and `pop`. It also owns interrupt entry on `eint`, the HALT state, and a fetch watchdog.

## Interface
Parameters:
- `INT_VECTOR`, default 8'hF0: PC target loaded on interrupt entry.
- `FETCH_TIMEOUT`, default 255: maximum number of cycles to wait for `imem_ack` before flagging an error.

Ports:
- `clk`, in, 1: single clock; everything is rising-edge.
- `rst`, in, 1: synchronous, active-high reset.
- `eint`, in, 1: external interrupt request, level-sensitive.
- `PC`, in, 8: current program counter from the datapath.
- `CEENZ`, in, 1: datapath flag; 1 when CEE ≠ Lit.
- `imem_req`, out, 1: instruction fetch request.
- `imem_addr`, out, 8: fetch address; equals `PC` while `imem_req` is high.
- `imem_ack`, in, 1: fetch complete; `imem_data` is valid in the same cycle.
- `imem_data`, in, 16: instruction word.
- `calu`, out, 6: ALU operation select.
- `cpc`, out, 2: PC control. 00 hold, 01 increment, 10 load `Lit`, 11 load `Lit` if `CEENZ`, else increment.
- `csrc`, out, 2: register write source. 00 none, 01 ALU, 10 literal.
- `cmsrc`, out, 3: MUX source select.
- `Lit`, out, 8: literal operand or branch target.
- `addr`, out, 6: register or memory index.
- `wr_en`, out, 1: memory write strobe.
- `call`, `ret`, `push`, `pop`: out, 1 each; stack strobes.
- `halted`, out, 1: high while in HALT.
- `illegal`, out, 1: one-cycle pulse on an undefined opcode.
- `bus_err`, out, 1: one-cycle pulse on fetch timeout.

## Operation
- Instruction fields: op = ir[15:12], f = ir[11:8], k = ir[7:0].
- States: FETCH, EXEC, INT, HALT.
- FETCH:
  - Assert `imem_req`.
  - On `imem_ack`, latch `imem_data` into `ir` and go to EXEC.
  - A watchdog counter increments every FETCH cycle without ack. When it reaches `FETCH_TIMEOUT`, pulse `bus_err`, clear the counter and stay in FETCH; the retry uses the same PC.
  - The counter clears on every ack.
- EXEC: exactly one cycle; strobes are decoded from `ir`. Unlisted outputs are at their defaults.
  - 0x0 NOP: cpc=01.
  - 0x1 ALU: calu={2'b00,f}, Lit=k, csrc=01, addr={2'b00,f}, cpc=01.
  - 0x2 LDI: Lit=k, csrc=10, addr={2'b00,f}, cpc=01.
  - 0x3 ST: cmsrc=f[2:0], addr=k[5:0], wr_en=1, cpc=01.
  - 0x4 JMP: Lit=k, cpc=10.
  - 0x5 BNZ: Lit=k, cpc=11.
  - 0x6 CALL: Lit=k, call=1, cpc=10.
  - 0x7 RET: ret=1, cpc=00. The datapath restores PC. Clears `in_isr` if it is set.
  - 0x8 PUSH: cmsrc=f[2:0], push=1, cpc=01.
  - 0x9 POP: pop=1, addr={2'b00,f}, cpc=01.
  - 0xF HALT: cpc=00; next state is HALT.
  - 0xA–0xE: behave as NOP and pulse `illegal`.
- After EXEC:
  - If `eint` && !`in_isr` && op≠HALT, go to INT.
  - Otherwise go to FETCH.
- INT: one cycle with call=1, Lit=`INT_VECTOR`, cpc=10. Set `in_isr`, then go to FETCH.
- HALT:
  - All strobes are 0 and cpc=00; `halted`=1.
  - `eint` && !`in_isr` moves to INT.
  - Only `rst` leaves HALT otherwise.
- Nesting: interrupts do not nest. `eint` is ignored while `in_isr`=1.
- Defaults outside EXEC/INT: calu=0, cpc=00, csrc=00, cmsrc=0, Lit=0, addr=0, all strobes 0.

## Timing
- Reset (synchronous, takes effect at the clock edge):
  - state=FETCH, ir=16'h0000, `in_isr`=0, watchdog=0.
  - All outputs at their defaults; `imem_req` is 1 from the first cycle after reset.
- Reset mid-fetch or mid-EXEC aborts the instruction. No strobe is asserted in the cycle following the reset edge.
- Zero-wait memory (ack in the first FETCH cycle) gives 2 cycles per instruction: FETCH, EXEC.
- Each wait cycle adds 1 cycle per instruction.
- Interrupt entry adds 1 cycle (INT) after the current instruction's EXEC. The interrupted instruction always completes first.
- `eint` is sampled only in EXEC (on its last cycle) and in HALT. A pulse that is low at those points is missed; this is by design.
- `ack` and timeout in the same cycle: ack wins, no `bus_err`.
- `imem_addr` tracks `PC` combinationally. The datapath updates PC at the end of EXEC or INT, so FETCH always sees the new PC.
- `illegal` and `bus_err` are one-cycle pulses, registered off state and `ir`.

## Test plan
- Reset, then LDI 0x2305 with ack in the first cycle:
  - `imem_req`=1 in the cycle after reset.
  - Next cycle: csrc=10, addr=3, Lit=05, cpc=01.
  - The following cycle is FETCH again.
- BNZ 0x5040:
  - With CEENZ=1: cpc=11, Lit=40, and the PC model jumps to 0x40.
  - With CEENZ=0: the PC model increments.
- Raise `eint` during ALU 0x1207:
  - EXEC shows calu=02, Lit=07.
  - Next cycle INT: call=1, Lit=F0, cpc=10.
  - A second `eint` before RET 0x7000 is ignored.
  - After RET, `eint` is accepted again.
- Hold `imem_ack` low for 255 cycles:
  - `bus_err` pulses exactly once, at cycle 255.
  - Ack at cycle 300 proceeds normally with no further `bus_err`.
- Undefined opcode 0xB123: `illegal` pulses, cpc=01, no other strobes.
- HALT 0xF000:
  - `halted`=1 and strobes stay 0 for 20 cycles.
  - `eint` then triggers INT; `halted` drops.
- Assert `rst` during an INT cycle: the next cycle has all strobes 0 and state FETCH.

Source files
------------

// File: rtl/arm_sequencer_if.sv
// Instruction-memory fetch port shared by the sequencer (master) and program memory (slave).
interface arm_sequencer_if;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;

  modport master (output imem_req, imem_addr, input imem_ack, imem_data);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_data);
endinterface

// File: rtl/arm_sequencer.sv
// Instruction sequencer: fetches 16-bit words, decodes one execute cycle of datapath
// controls, and handles interrupt entry, HALT and the fetch watchdog.
module arm_sequencer #(
  parameter logic [7:0]  INT_VECTOR    = 8'hF0,
  parameter int unsigned FETCH_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            eint,
  input  logic [7:0]      PC,
  input  logic            CEENZ,
  arm_sequencer_if.master imem,
  output logic [5:0]      calu,
  output logic [1:0]      cpc,
  output logic [1:0]      csrc,
  output logic [2:0]      cmsrc,
  output logic [7:0]      Lit,
  output logic [5:0]      addr,
  output logic            wr_en,
  output logic            call,
  output logic            ret,
  output logic            push,
  output logic            pop,
  output logic            halted,
  output logic            illegal,
  output logic            bus_err
);

  localparam int WD_W = (FETCH_TIMEOUT < 2) ? 1 : $clog2(FETCH_TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(FETCH_TIMEOUT - 1);

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_INT, S_HALT} state_t;

  state_t          state, state_nx;
  logic [15:0]     ir;
  logic            in_isr, in_isr_nx;
  logic [WD_W-1:0] wdog, wdog_nx;
  logic            bus_err_nx;

  logic [3:0] op;
  logic [3:0] f;
  logic [7:0] k;

  assign op = ir[15:12];
  assign f  = ir[11:8];
  assign k  = ir[7:0];

  assign imem.imem_addr = PC;

  // The conditional branch is resolved by the datapath from cpc=11.
  logic unused_ceenz;
  assign unused_ceenz = CEENZ;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_FETCH;
      ir      <= 16'h0000;
      in_isr  <= 1'b0;
      wdog    <= '0;
      bus_err <= 1'b0;
    end else begin
      state   <= state_nx;
      in_isr  <= in_isr_nx;
      wdog    <= wdog_nx;
      bus_err <= bus_err_nx;
      if (state == S_FETCH && imem.imem_ack) ir <= imem.imem_data;
    end
  end

  always_comb begin
    state_nx      = state;
    in_isr_nx     = in_isr;
    wdog_nx       = wdog;
    bus_err_nx    = 1'b0;
    imem.imem_req = 1'b0;
    calu          = 6'd0;
    cpc           = 2'b00;
    csrc          = 2'b00;
    cmsrc         = 3'd0;
    Lit           = 8'h00;
    addr          = 6'd0;
    wr_en         = 1'b0;
    call          = 1'b0;
    ret           = 1'b0;
    push          = 1'b0;
    pop           = 1'b0;
    halted        = 1'b0;
    illegal       = 1'b0;

    case (state)
      S_FETCH: begin
        imem.imem_req = 1'b1;
        // An ack in the timeout cycle wins over the watchdog.
        if (imem.imem_ack) begin
          state_nx = S_EXEC;
          wdog_nx  = '0;
        end else if (wdog == WD_LAST) begin
          bus_err_nx = 1'b1;
          wdog_nx    = '0;
        end else begin
          wdog_nx = wdog + 1'b1;
        end
      end

      S_EXEC: begin
        cpc = 2'b01;
        case (op)
          4'h0: ;
          4'h1: begin
            calu = {2'b00, f};
            Lit  = k;
            csrc = 2'b01;
            addr = {2'b00, f};
          end
          4'h2: begin
            Lit  = k;
            csrc = 2'b10;
            addr = {2'b00, f};
          end
          4'h3: begin
            cmsrc = f[2:0];
            addr  = k[5:0];
            wr_en = 1'b1;
          end
          4'h4: begin
            Lit = k;
            cpc = 2'b10;
          end
          4'h5: begin
            Lit = k;
            cpc = 2'b11;
          end
          4'h6: begin
            Lit  = k;
            call = 1'b1;
            cpc  = 2'b10;
          end
          4'h7: begin
            ret       = 1'b1;
            cpc       = 2'b00;
            in_isr_nx = 1'b0;
          end
          4'h8: begin
            cmsrc = f[2:0];
            push  = 1'b1;
          end
          4'h9: begin
            pop  = 1'b1;
            addr = {2'b00, f};
          end
          4'hF: cpc = 2'b00;
          default: illegal = 1'b1;
        endcase

        // in_isr is the pre-instruction value, so the RET cycle itself cannot re-enter.
        if (op == 4'hF)             state_nx = S_HALT;
        else if (eint && !in_isr)   state_nx = S_INT;
        else                        state_nx = S_FETCH;
      end

      S_INT: begin
        call      = 1'b1;
        Lit       = INT_VECTOR;
        cpc       = 2'b10;
        in_isr_nx = 1'b1;
        state_nx  = S_FETCH;
      end

      S_HALT: begin
        halted = 1'b1;
        if (eint && !in_isr) state_nx = S_INT;
      end

      default: state_nx = S_FETCH;
    endcase
  end

endmodule
